instruction_fetch: RTL and testbench

//  Producer side of the fetch->decode interface. Holds the PC and issues word

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch unit: holds the PC, issues one word read at a time and buffers
// returned {pc,instr} pairs for decode; redirects flush everything in flight.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_C = AW'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   tag;
  logic [31:0]   fifo_pc  [FIFO_DEPTH];
  logic [31:0]   fifo_ins [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic push;
  logic pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + AW'(1);
  endfunction

  assign imem_req_valid = rst_n && (state == S_IDLE)
                       && (count != FULL_C) && !redirect_valid;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid
                       && !redirect_valid;

  assign instr_valid = rst_n && (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = instr_valid ? fifo_ins[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]  : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      tag    <= 32'h0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          tag   <= pc;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid)      state <= S_IDLE;
          else if (redirect_valid) state <= S_DROP;
        end
        S_DROP: if (imem_rsp_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (redirect_valid)
        pc <= redirect_pc & ~32'h3;
      else if (accept)
        pc <= pc + 32'd4;

      // a redirect drops both buffered entries and any same-cycle response
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop)  rd_ptr <= nxt(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= tag;
      fifo_ins[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised and directed bench for instruction_fetch against a
// queue-based transaction model of fetch, memory and decode.
module tb_instruction_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc = RPC;
  logic [31:0] m_tag = 32'h0;
  bit          m_out = 0;
  bit          m_disc = 0;
  logic [63:0] q[$];

  bit          pend = 0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  int          mem_delay = 0;
  bit          rand_mode = 0;

  logic [31:0] acc_log[$];
  logic [63:0] pop_log[$];
  int          cyc = 0;
  int          first_acc = -1;
  int          first_val = -1;
  bit          last_acc = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'hDEAD_0000) + 32'h100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    bit exp_req, exp_iv, acc, pushv;
    pushv = 0;
    if (rand_mode) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0)
                     ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                     : {20'h0, 12'($urandom)};
      rst_n          = ($urandom_range(0, 299) != 0);
    end
    imem_rsp_valid = pend && (pend_cnt == 0);
    imem_rdata     = imem_rsp_valid ? memf(pend_addr) : $urandom;
    @(negedge clk);
    exp_req = rst_n && !m_out && (q.size() < DEPTH) && !redirect_valid;
    exp_iv  = rst_n && (q.size() > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("instr_pc", instr_pc, q[0][63:32]);
      chk("instr_out", instr_out, q[0][31:0]);
    end
    if (!rst_n) begin
      chk("rst_instr_out", instr_out, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
    end
    acc = exp_req && imem_req_ready;
    cyc++;
    last_acc = acc;
    if (acc && first_acc < 0) first_acc = cyc;
    if (exp_iv && first_val < 0) first_val = cyc;

    if (imem_rsp_valid) pend = 0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (!rst_n && pend) pend_cnt = 0;
    if (acc) begin
      pend      = 1;
      pend_addr = m_pc;
      pend_cnt  = rand_mode ? int'($urandom_range(0, 2)) : mem_delay;
      acc_log.push_back(m_pc);
    end

    if (exp_iv && instr_ready) pop_log.push_back(q[0]);
    if (!rst_n) begin
      q.delete();
      m_out = 0;
      m_disc = 0;
      m_pc = RPC;
    end else begin
      if (m_out && imem_rsp_valid) begin
        m_out = 0;
        pushv = !m_disc && !redirect_valid;
      end else if (m_out && redirect_valid) begin
        m_disc = 1;
      end
      if (exp_iv && instr_ready) void'(q.pop_front());
      if (pushv) q.push_back({m_tag, imem_rdata});
      if (redirect_valid) begin
        q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (acc) begin
        m_tag  = m_pc;
        m_out  = 1;
        m_disc = 0;
        m_pc   = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rand_mode = 0;
    rst_n = 0;
    redirect_valid = 0;
    instr_ready = 0;
    imem_req_ready = 0;
    tick();
    tick();
    rst_n = 1;
    acc_log.delete();
    pop_log.delete();
    cyc = 0;
    first_acc = -1;
    first_val = -1;
  endtask

  task automatic run_until_acc(input logic [31:0] a, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (last_acc && acc_log[$] == a) found = 1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1;
    redirect_pc = a;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    int n, na, bad;

    // 1: streaming with a 1-cycle memory
    reset_dut();
    mem_delay = 0;
    imem_req_ready = 1;
    instr_ready = 1;
    repeat (10) tick();
    chk("t1_addr0", acc_log[0], 32'h0);
    chk("t1_addr1", acc_log[1], 32'h4);
    chk("t1_addr2", acc_log[2], 32'h8);
    chk("t1_pc0", pop_log[0][63:32], 32'h0);
    chk("t1_pc1", pop_log[1][63:32], 32'h4);
    chk("t1_pc2", pop_log[2][63:32], 32'h8);
    chk("t1_word0", pop_log[0][31:0], 32'h0000_0013);
    chk("t1_latency", 32'(first_val - first_acc), 32'd2);

    // 2: decode stalled fills the buffer then fetch stops
    reset_dut();
    imem_req_ready = 1;
    repeat (10) tick();
    chk("t2_nacc", 32'(acc_log.size()), 32'd2);
    chk("t2_req_idle", 32'(imem_req_valid), 32'd0);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_ins", instr_out, 32'h0000_0013);
    instr_ready = 1;
    tick();
    instr_ready = 0;
    repeat (4) tick();
    chk("t2_nacc2", 32'(acc_log.size()), 32'd3);
    chk("t2_addr8", acc_log[2], 32'h8);

    // 3: redirect while waiting on 0x8
    reset_dut();
    mem_delay = 1;
    imem_req_ready = 1;
    instr_ready = 1;
    run_until_acc(32'h8, "t3_wait8");
    n = pop_log.size();
    redirect_to(32'h100);
    chk("t3_flush", 32'(instr_valid), 32'd0);
    repeat (12) tick();
    chk("t3_next", pop_log[n][63:32], 32'h100);
    bad = 0;
    foreach (pop_log[i]) if (pop_log[i][63:32] == 32'h8) bad++;
    chk("t3_no8", 32'(bad), 32'd0);

    // 4: redirect coincides with the response for 0xC
    reset_dut();
    mem_delay = 0;
    imem_req_ready = 1;
    instr_ready = 1;
    run_until_acc(32'hC, "t4_waitC");
    n = pop_log.size();
    redirect_to(32'h200);
    chk("t4_flush", 32'(instr_valid), 32'd0);
    repeat (8) tick();
    chk("t4_next", pop_log[n][63:32], 32'h200);
    bad = 0;
    foreach (pop_log[i]) if (pop_log[i][63:32] == 32'hC) bad++;
    chk("t4_noC", 32'(bad), 32'd0);

    // 5: misaligned redirect and PC wrap
    na = acc_log.size();
    redirect_to(32'h103);
    repeat (4) tick();
    chk("t5_align", acc_log[na], 32'h100);
    na = acc_log.size();
    redirect_to(32'hFFFF_FFFC);
    repeat (6) tick();
    chk("t5_top", acc_log[na], 32'hFFFF_FFFC);
    chk("t5_wrap", acc_log[na+1], 32'h0);

    // 6: reset while a request is outstanding
    reset_dut();
    mem_delay = 2;
    imem_req_ready = 1;
    run_until_acc(32'h4, "t6_wait4");
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t6_flush", 32'(instr_valid), 32'd0);
    n = pop_log.size();
    na = acc_log.size();
    mem_delay = 0;
    instr_ready = 1;
    repeat (6) tick();
    chk("t6_refetch", acc_log[na], RPC);
    chk("t6_pop_pc", pop_log[n][63:32], 32'h0);
    chk("t6_pop_ins", pop_log[n][31:0], 32'h0000_0013);

    // random traffic
    reset_dut();
    rand_mode = 1;
    repeat (4000) tick();
    rand_mode = 0;
    rst_n = 1;
    redirect_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
